charlie_frame_decoder: RTL and testbench



---
 rtl/charlie_pkg.sv | 26 ++
 rtl/charlie_slot_decode.sv | 31 +++
 rtl/charlie_frame_decoder.sv | 139 +++++++++++++
 tb/tb_charlie_frame_decoder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/charlie_pkg.sv
// Shared types and helpers for the charlieplexed display path: default geometry,
// decoder FSM states, column-to-pin mapping and anode detection.
package charlie_pkg;
    localparam int CHARLIE_ROWS = 6;

    typedef enum logic [1:0] {HUNT, SYNC, LOCK} state_t;

    // Column c of row r sits on pin c below the anode and on pin c+1 above it.
    function automatic int col_pin(input int row, input int col);
        return (col < row) ? col : col + 1;
    endfunction

    function automatic int anode_count(input logic [31:0] anodes);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) n += int'(anodes[i]);
        return n;
    endfunction

    function automatic int anode_index(input logic [31:0] anodes);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) if (anodes[i]) idx = i;
        return idx;
    endfunction
endpackage

// File: rtl/charlie_slot_decode.sv
// Combinational decode of one registered pin sample: single-anode check, row index
// and the columns sinking current (driven low) in that row.
module charlie_slot_decode
    import charlie_pkg::*;
#(
    parameter int ROWS = CHARLIE_ROWS,
    localparam int ROW_W = $clog2(ROWS)
) (
    input  logic [ROWS-1:0]  i_drv,
    input  logic [ROWS-1:0]  i_oe,
    output logic             o_slot_valid,
    output logic [ROW_W-1:0] o_row,
    output logic [ROWS-2:0]  o_cols
);
    logic [31:0]     w_anodes;
    logic [ROWS-1:0] w_sinks;
    int              w_row;

    assign w_anodes = 32'(i_drv & i_oe);
    assign w_sinks  = i_oe & ~i_drv;

    always_comb begin
        w_row        = anode_index(w_anodes);
        o_slot_valid = (anode_count(w_anodes) == 1);
        o_row        = ROW_W'(w_row);
        o_cols       = '0;
        for (int c = 0; c < ROWS - 1; c++)
            for (int p = 0; p < ROWS; p++)
                if (p == col_pin(w_row, c)) o_cols[c] = w_sinks[p];
    end
endmodule

// File: rtl/charlie_frame_decoder.sv
// Charlieplexed scan monitor: rebuilds the ROWS x (ROWS-1) frame from sampled pins and tracks scan lock.
// Build macro CHARLIE_FRAME_CMP_EN adds frame_changed, flagging commits that differ from the last frame.
module charlie_frame_decoder
    import charlie_pkg::*;
#(
    parameter int ROWS     = CHARLIE_ROWS,
    parameter int MAX_HOLD = 255,
    parameter int HOLD_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ROWS-1:0]          pin_drv,
    input  logic [ROWS-1:0]          pin_oe,
    output logic [ROWS*(ROWS-1)-1:0] pixels,
    output logic                     frame_valid,
    output logic                     locked,
    output logic                     sync_err
`ifdef CHARLIE_FRAME_CMP_EN
    ,
    output logic                     frame_changed
`endif
);
    localparam int                COLS       = ROWS - 1;
    localparam int                ROW_W      = $clog2(ROWS);
    localparam int                PIX_W      = ROWS * COLS;
    localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(ROWS - 1);
    // r_hold counts repeats after the capture cycle, so the row has been up r_hold+1 cycles.
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 2);

    logic [ROWS-1:0]   r_drv_p1;
    logic [ROWS-1:0]   r_oe_p1;
    state_t            r_state;
    logic [ROW_W-1:0]  r_last_row;
    logic [HOLD_W-1:0] r_hold;
    logic [PIX_W-1:0]  r_buf;

    logic              w_slot_valid;
    logic [ROW_W-1:0]  w_row;
    logic [COLS-1:0]   w_cols;
    logic [ROW_W-1:0]  w_next_row;
    logic              w_is_hold;
    logic              w_is_next;
    logic              w_hold_out;
    logic              w_wrap;
    logic              w_seq_err;

    function automatic logic [PIX_W-1:0] row_insert(input logic [PIX_W-1:0] frame,
                                                    input logic [ROW_W-1:0] row,
                                                    input logic [COLS-1:0]  cols);
        logic [PIX_W-1:0] res;
        res = frame;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (ROW_W'(r) == row) res[r*COLS + c] = cols[c];
        return res;
    endfunction

    // Stage 1: pin sample register
    always_ff @(posedge clk) begin
        r_drv_p1 <= pin_drv;
        r_oe_p1  <= pin_oe;
    end

    charlie_slot_decode #(.ROWS(ROWS)) u_slot_decode (
        .i_drv        (r_drv_p1),
        .i_oe         (r_oe_p1),
        .o_slot_valid (w_slot_valid),
        .o_row        (w_row),
        .o_cols       (w_cols)
    );

    always_comb begin
        w_next_row = (r_last_row == LAST_ROW) ? '0 : r_last_row + ROW_W'(1);
        w_is_hold  = w_slot_valid && (w_row == r_last_row);
        w_is_next  = w_slot_valid && (w_row == w_next_row);
        w_hold_out = w_is_hold && (r_hold == HOLD_LIMIT);
        w_wrap     = w_is_next && (r_last_row == LAST_ROW);
        w_seq_err  = !(w_is_hold || w_is_next) || w_hold_out;
    end

    // Stage 2: scan tracking, frame buffer and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= HUNT;
            r_last_row    <= '0;
            r_hold        <= '0;
            r_buf         <= '0;
            pixels        <= '0;
            frame_valid   <= 1'b0;
            locked        <= 1'b0;
            sync_err      <= 1'b0;
`ifdef CHARLIE_FRAME_CMP_EN
            frame_changed <= 1'b0;
`endif
        end else begin
            frame_valid   <= 1'b0;
            sync_err      <= 1'b0;
`ifdef CHARLIE_FRAME_CMP_EN
            frame_changed <= 1'b0;
`endif
            case (r_state)
                HUNT: begin
                    if (w_slot_valid && (w_row == '0)) begin
                        r_state    <= SYNC;
                        r_last_row <= '0;
                        r_hold     <= '0;
                        r_buf      <= row_insert('0, w_row, w_cols);
                    end
                end
                default: begin
                    if (w_seq_err) begin
                        r_state  <= HUNT;
                        locked   <= 1'b0;
                        sync_err <= 1'b1;
                    end else if (w_is_hold) begin
                        r_hold <= r_hold + HOLD_W'(1);
                        r_buf  <= row_insert(r_buf, w_row, w_cols);
                    end else begin
                        r_last_row <= w_row;
                        r_hold     <= '0;
                        if (w_wrap) begin
                            // Row 0 closes the frame: publish it, then restart the buffer with this row.
                            pixels        <= r_buf;
                            frame_valid   <= 1'b1;
                            locked        <= 1'b1;
                            r_state       <= LOCK;
                            r_buf         <= row_insert('0, w_row, w_cols);
`ifdef CHARLIE_FRAME_CMP_EN
                            frame_changed <= (r_buf != pixels);
`endif
                        end else begin
                            r_buf <= row_insert(r_buf, w_row, w_cols);
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_charlie_frame_decoder.sv
// Directed bench for charlie_frame_decoder: a vector table for scan/lock/error behaviour,
// plus hand-written idle, hold-timeout and mid-frame reset sequences.
module tb_charlie_frame_decoder;
    localparam logic [29:0] F1 = 30'h3041041;  // bits 0,6,12,18,24,25
    localparam logic [29:0] F2 = 30'h3441041;  // F1 plus row 4 column 2 (bit 22)

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  pin_drv;
    logic [5:0]  pin_oe;
    logic [29:0] pixels;
    logic        frame_valid;
    logic        locked;
    logic        sync_err;
`ifdef CHARLIE_FRAME_CMP_EN
    logic        frame_changed;
`endif

    always #5 clk = ~clk;

    charlie_frame_decoder dut (
        .clk           (clk),
        .rst           (rst),
        .pin_drv       (pin_drv),
        .pin_oe        (pin_oe),
        .pixels        (pixels),
        .frame_valid   (frame_valid),
        .locked        (locked),
        .sync_err      (sync_err)
`ifdef CHARLIE_FRAME_CMP_EN
        ,
        .frame_changed (frame_changed)
`endif
    );

    typedef struct {
        logic [5:0]  drv;
        logic [5:0]  oe;
        logic        fv;
        logic        err;
        logic        lk;
        logic        chg;
        logic [29:0] pix;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   fv_cnt   = 0;
    int   err_cnt  = 0;
    int   s_fv;
    int   s_err;

    always @(posedge clk) begin
        #1;
        if (frame_valid) fv_cnt++;
        if (sync_err) err_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] slot_pins(input int row, input logic [4:0] cols);
        logic [5:0] drv;
        logic [5:0] oe;
        drv = '0;
        for (int p = 0; p < 6; p++) if (p == row) drv[p] = 1'b1;
        oe = drv;
        for (int c = 0; c < 5; c++)
            for (int p = 0; p < 6; p++)
                if (cols[c] && (p == ((c < row) ? c : c + 1))) oe[p] = 1'b1;
        return {drv, oe};
    endfunction

    task automatic addv(input logic [11:0] p, input logic fv, input logic err, input logic lk,
                        input logic chg, input logic [29:0] pix);
        vec_t v;
        v.drv = p[11:6];
        v.oe  = p[5:0];
        v.fv  = fv;
        v.err = err;
        v.lk  = lk;
        v.chg = chg;
        v.pix = pix;
        vecs.push_back(v);
    endtask

    task automatic apply_slot(input int row, input logic [4:0] cols);
        @(negedge clk);
        {pin_drv, pin_oe} = slot_pins(row, cols);
    endtask

    task automatic scan_frame();
        for (int r = 0; r < 6; r++) apply_slot(r, 5'(1 << (r % 5)));
        apply_slot(0, 5'b00001);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        pin_drv = '0;
        pin_oe = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        pin_drv = '0;
        pin_oe = '0;

        // Ideal scan and lock
        addv(slot_pins(0, 5'b00001), 0, 0, 0, 0, 30'h0);
        addv(slot_pins(1, 5'b00010), 0, 0, 0, 0, 30'h0);
        addv(slot_pins(2, 5'b00100), 0, 0, 0, 0, 30'h0);
        addv(slot_pins(3, 5'b01000), 0, 0, 0, 0, 30'h0);
        addv(slot_pins(4, 5'b10000), 0, 0, 0, 0, 30'h0);
        addv(slot_pins(5, 5'b00001), 0, 0, 0, 0, 30'h0);
        addv(slot_pins(0, 5'b00001), 1, 0, 1, 1, F1);
        // Second identical frame
        addv(slot_pins(1, 5'b00010), 0, 0, 1, 0, F1);
        addv(slot_pins(2, 5'b00100), 0, 0, 1, 0, F1);
        addv(slot_pins(3, 5'b01000), 0, 0, 1, 0, F1);
        addv(slot_pins(4, 5'b10000), 0, 0, 1, 0, F1);
        addv(slot_pins(5, 5'b00001), 0, 0, 1, 0, F1);
        addv(slot_pins(0, 5'b00001), 1, 0, 1, 0, F1);
        // Skipped row 2, then relock with row 4 column 2 added
        addv(slot_pins(1, 5'b00010), 0, 0, 1, 0, F1);
        addv(slot_pins(3, 5'b01000), 0, 1, 0, 0, F1);
        addv(slot_pins(0, 5'b00001), 0, 0, 0, 0, F1);
        addv(slot_pins(1, 5'b00010), 0, 0, 0, 0, F1);
        addv(slot_pins(2, 5'b00100), 0, 0, 0, 0, F1);
        addv(slot_pins(3, 5'b01000), 0, 0, 0, 0, F1);
        addv(slot_pins(4, 5'b10100), 0, 0, 0, 0, F1);
        addv(slot_pins(5, 5'b00001), 0, 0, 0, 0, F1);
        addv(slot_pins(0, 5'b00001), 1, 0, 1, 1, F2);
        // Double anode while locked, then in HUNT, then idle
        addv(slot_pins(1, 5'b00010), 0, 0, 1, 0, F2);
        addv({6'b001001, 6'b001001},  0, 1, 0, 0, F2);
        addv({6'b001001, 6'b001001},  0, 0, 0, 0, F2);
        addv({6'b000000, 6'b000000},  0, 0, 0, 0, F2);

        repeat (3) @(negedge clk);
        chk("reset pixels", 64'(pixels), 64'(0));
        chk("reset frame_valid", 64'(frame_valid), 64'(0));
        chk("reset locked", 64'(locked), 64'(0));
        chk("reset sync_err", 64'(sync_err), 64'(0));
`ifdef CHARLIE_FRAME_CMP_EN
        chk("reset frame_changed", 64'(frame_changed), 64'(0));
`endif
        rst = 1'b0;

        for (int i = 0; i < vecs.size() + 2; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                chk($sformatf("vec%0d frame_valid", i - 2), 64'(frame_valid), 64'(vecs[i-2].fv));
                chk($sformatf("vec%0d sync_err", i - 2), 64'(sync_err), 64'(vecs[i-2].err));
                chk($sformatf("vec%0d locked", i - 2), 64'(locked), 64'(vecs[i-2].lk));
                chk($sformatf("vec%0d pixels", i - 2), 64'(pixels), 64'(vecs[i-2].pix));
`ifdef CHARLIE_FRAME_CMP_EN
                chk($sformatf("vec%0d frame_changed", i - 2), 64'(frame_changed), 64'(vecs[i-2].chg));
`endif
            end
            if (i < vecs.size()) begin
                pin_drv = vecs[i].drv;
                pin_oe  = vecs[i].oe;
            end
        end

        // All pins high-Z
        do_reset();
        s_fv = fv_cnt;
        s_err = err_cnt;
        repeat (300) @(negedge clk);
        chk("idle frame_valid count", 64'(fv_cnt - s_fv), 64'(0));
        chk("idle sync_err count", 64'(err_cnt - s_err), 64'(0));
        chk("idle locked", 64'(locked), 64'(0));

        // Row held 254 cycles is tolerated, 255 cycles times out
        do_reset();
        scan_frame();
        repeat (2) @(negedge clk);
        chk("hold pre locked", 64'(locked), 64'(1));
        s_err = err_cnt;
        apply_slot(1, 5'b00010);
        repeat (254) apply_slot(2, 5'b00100);
        apply_slot(3, 5'b01000);
        apply_slot(4, 5'b10000);
        apply_slot(5, 5'b00001);
        apply_slot(0, 5'b00001);
        repeat (2) @(negedge clk);
        chk("hold254 sync_err count", 64'(err_cnt - s_err), 64'(0));
        chk("hold254 locked", 64'(locked), 64'(1));
        apply_slot(1, 5'b00010);
        repeat (255) apply_slot(2, 5'b00100);
        @(negedge clk);
        chk("hold255 before sync_err", 64'(sync_err), 64'(0));
        chk("hold255 before locked", 64'(locked), 64'(1));
        @(negedge clk);
        chk("hold255 sync_err", 64'(sync_err), 64'(1));
        chk("hold255 locked", 64'(locked), 64'(0));
        @(negedge clk);
        chk("hold255 pulse width", 64'(sync_err), 64'(0));
        chk("hold255 sync_err count", 64'(err_cnt - s_err), 64'(1));

        // Reset in the middle of a frame
        scan_frame();
        repeat (2) @(negedge clk);
        chk("midrst pre pixels", 64'(pixels), 64'(F1));
        chk("midrst pre locked", 64'(locked), 64'(1));
        apply_slot(1, 5'b00010);
        apply_slot(2, 5'b00100);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst pixels", 64'(pixels), 64'(0));
        chk("midrst frame_valid", 64'(frame_valid), 64'(0));
        chk("midrst locked", 64'(locked), 64'(0));
        chk("midrst sync_err", 64'(sync_err), 64'(0));
`ifdef CHARLIE_FRAME_CMP_EN
        chk("midrst frame_changed", 64'(frame_changed), 64'(0));
`endif
        rst = 1'b0;
        s_fv = fv_cnt;
        apply_slot(3, 5'b01000);
        apply_slot(4, 5'b10000);
        apply_slot(5, 5'b00001);
        apply_slot(0, 5'b00001);
        repeat (2) @(negedge clk);
        chk("midrst no partial commit", 64'(fv_cnt - s_fv), 64'(0));
        chk("midrst pixels stay 0", 64'(pixels), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
